// File: rtl/poly_mem_pkg.sv
// Shared defaults, index/coefficient types and a width helper for the
// polynomial coefficient memory crossbar.
package poly_mem_pkg;

    localparam int DEF_NUM_PORTS = 3;
    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_N         = 256;
    localparam int DEF_W         = 16;

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [idx_w(DEF_NUM_PORTS)-1:0] port_idx_t;
    typedef logic [idx_w(DEF_NUM_BANKS)-1:0] bank_idx_t;
    typedef logic [DEF_W-1:0]                coeff_t;

endpackage

// File: rtl/poly_bank_sp.sv
// Single-port N x W coefficient bank with synchronous read; one access per cycle.
module poly_bank_sp
    import poly_mem_pkg::*;
#(
    parameter  int N      = DEF_N,
    parameter  int W      = DEF_W,
    localparam int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [W-1:0]      wdata,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [N];

    // NOTE: the array has no reset -- clearing N entries would prevent RAM
    // inference, and coefficients are expected to survive a reset anyway.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values no matter how processes are ordered.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/poly_mem_xbar.sv
// Multi-port crossbar onto banked coefficient memory with a round-robin
// arbiter per bank and one-cycle read latency.
module poly_mem_xbar
    import poly_mem_pkg::*;
#(
    parameter  int NUM_PORTS = DEF_NUM_PORTS,
    parameter  int NUM_BANKS = DEF_NUM_BANKS,
    parameter  int N         = DEF_N,
    parameter  int W         = DEF_W,
    localparam int ADDR_W    = $clog2(N),
    localparam int BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS-1:0]                req,
    input  logic [NUM_PORTS-1:0]                we,
    input  logic [NUM_PORTS-1:0][BANK_W-1:0]    bank,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    addr,
    input  logic [NUM_PORTS-1:0][W-1:0]         wdata,
    output logic [NUM_PORTS-1:0]                gnt,
    output logic [NUM_PORTS-1:0]                stall,
    output logic [NUM_PORTS-1:0]                rvalid,
    output logic [NUM_PORTS-1:0][W-1:0]         rdata
);

    localparam int              PORT_W = idx_w(NUM_PORTS);
    localparam logic [PORT_W:0] NP_L   = (PORT_W+1)'(NUM_PORTS);

    logic [NUM_BANKS-1:0][NUM_PORTS-1:0] bank_gnt;
    logic [NUM_BANKS-1:0][W-1:0]         bank_rdata;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [NUM_PORTS-1:0] cand;
        logic [NUM_PORTS-1:0] sel;
        logic [PORT_W-1:0]    rr_ptr;
        logic [PORT_W-1:0]    win;
        logic [PORT_W:0]      idx;
        logic [PORT_W:0]      nxt;
        logic                 hit;
        logic                 b_we;
        logic [ADDR_W-1:0]    b_addr;
        logic [W-1:0]         b_wdata;

        // NOTE: every always_comb output gets a default before any branch,
        // otherwise a missed path infers a latch.
        always_comb begin
            cand = '0;
            for (int p = 0; p < NUM_PORTS; p++)
                cand[p] = req[p] && !rst && (bank[p] == BANK_W'(b));
        end

        // Search upward from rr_ptr, wrapping at NUM_PORTS; first hit wins.
        always_comb begin
            hit     = 1'b0;
            win     = '0;
            sel     = '0;
            idx     = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                idx = {1'b0, rr_ptr} + (PORT_W+1)'(i);
                if (idx >= NP_L) idx = idx - NP_L;
                if (!hit && cand[idx[PORT_W-1:0]]) begin
                    hit = 1'b1;
                    win = idx[PORT_W-1:0];
                end
            end
            if (hit) sel[win] = 1'b1;
            nxt = {1'b0, win} + (PORT_W+1)'(1);
            if (nxt == NP_L) nxt = '0;
            b_we    = we[win];
            b_addr  = addr[win];
            b_wdata = wdata[win];
        end

        always_ff @(posedge clk) begin
            if (rst)      rr_ptr <= '0;
            else if (hit) rr_ptr <= nxt[PORT_W-1:0];
        end

        poly_bank_sp #(.N(N), .W(W)) u_bank (
            .clk   (clk),
            .en    (hit),
            .we    (b_we),
            .addr  (b_addr),
            .wdata (b_wdata),
            .rdata (bank_rdata[b])
        );

        assign bank_gnt[b] = sel;
    end

    logic [NUM_PORTS-1:0]              rvalid_q;
    logic [NUM_PORTS-1:0][BANK_W-1:0]  rd_bank_q;
    logic [NUM_PORTS-1:0][W-1:0]       rdata_hold;

    always_comb begin
        gnt = '0;
        for (int b = 0; b < NUM_BANKS; b++) gnt = gnt | bank_gnt[b];
    end

    assign stall  = req & ~gnt & {NUM_PORTS{~rst}};
    assign rvalid = rvalid_q & {NUM_PORTS{~rst}};

    // Bank output register supplies fresh data; otherwise the last value is held.
    always_comb begin
        rdata = rdata_hold;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rst)              rdata[p] = '0;
            else if (rvalid_q[p]) rdata[p] = bank_rdata[rd_bank_q[p]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q   <= '0;
            rd_bank_q  <= '0;
            rdata_hold <= '0;
        end else begin
            rvalid_q   <= gnt & ~we;
            rd_bank_q  <= bank;
            rdata_hold <= rdata;
        end
    end

endmodule

// File: doc/poly_mem_xbar.md
POLY_MEM_XBAR -- requirements
Module: poly_mem_xbar

Interface
REQ-001 Parameter NUM_PORTS, default 3: number of independent requester ports (NTT, PolyMul, Pack/Unpack, ...).
REQ-002 Parameter NUM_BANKS, default 4: number of coefficient banks, power of two, at least 2.
REQ-003 Parameter N, default 256: coefficients per bank.
REQ-004 Parameter W, default 16: coefficient width in bits.
REQ-005 Derived ADDR_W = $clog2(N) and BANK_W = $clog2(NUM_BANKS); these are localparams, not overridable.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 req  input  [NUM_PORTS]  per-port access request.
REQ-009 we  input  [NUM_PORTS]  per-port write enable; 0 means read.
REQ-010 bank  input  [NUM_PORTS][BANK_W]  target bank per port.
REQ-011 addr  input  [NUM_PORTS][ADDR_W]  coefficient index within the bank.
REQ-012 wdata  input  [NUM_PORTS][W]  write data.
REQ-013 gnt  output  [NUM_PORTS]  combinational grant: the access is accepted this cycle.
REQ-014 stall  output  [NUM_PORTS]  equals req & ~gnt.
REQ-015 rvalid  output  [NUM_PORTS]  registered; read data valid.
REQ-016 rdata  output  [NUM_PORTS][W]  registered read data.

Function
REQ-017 Each bank SHALL perform at most one access (read or write) per cycle.
REQ-018 Per bank, arbitration SHALL be round-robin among the ports with req=1 that target that bank. The search SHALL start at that bank's pointer rr_ptr[b] and step upward, wrapping from NUM_PORTS-1 to 0.
REQ-019 On a grant to port p, rr_ptr[b] SHALL become (p+1) mod NUM_PORTS at the clock edge. It SHALL be unchanged if bank b grants nothing.
REQ-020 Ports that target different banks SHALL all be granted in the same cycle, with no interaction between them.
REQ-021 A granted write SHALL commit wdata to mem[bank][addr] at the clock edge of the grant cycle.
REQ-022 A granted read SHALL produce rvalid[p]=1 and rdata[p]=mem[bank][addr] exactly one cycle after the grant, so read latency is 1.
REQ-023 When rvalid[p]=0, rdata[p] SHALL hold its last value.
REQ-024 A read granted in the cycle after a write to the same location SHALL return the new data.
REQ-025 A port that is stalled SHALL hold req, we, bank, addr and wdata stable until it is granted. Fairness holds only under this rule.
REQ-026 Under this rule, a requester SHALL wait at most NUM_PORTS-1 cycles before it is granted.
REQ-027 gnt SHALL never be asserted for a port with req=0.
REQ-028 For each bank, gnt SHALL be asserted for at most one port.

Reset
REQ-029 While rst=1, gnt, stall and rvalid SHALL be 0, every rr_ptr SHALL be 0, rdata SHALL be 0, and no write SHALL commit.
REQ-030 Memory contents SHALL NOT be cleared by reset.
REQ-031 A read granted in the cycle before rst rises SHALL NOT produce rvalid after reset.
REQ-032 After rst deasserts, the first arbitration cycle SHALL give priority to port 0.

Structure
REQ-033 Package poly_mem_pkg SHALL hold the default parameters, the port-index and bank-index typedefs, and the coefficient typedef coeff_t.
REQ-034 Storage SHALL be NUM_BANKS instances of a sub-module poly_bank_sp: single-port, synchronous read, N x W, with no reset on the array.
REQ-035 The round-robin arbiter SHALL be generated once per bank inside poly_mem_xbar.

Verification
REQ-036 Ramp: port 0 writes bank 0, addr i, data 3i+7 for i=0..31, then reads all 32 back. Required: gnt every cycle, and rvalid one cycle later with rdata=3i+7.
REQ-037 Parallel: port 0, port 1 and port 2 read banks 0, 1 and 2 at addr 5 in the same cycle. Required: all three gnt=1, stall=0, and all three rvalid=1 on the next cycle.
REQ-038 Conflict fairness: all three ports hold a read of bank 3 from reset. Required: grants go to port 0, 1, 2 on consecutive cycles, and stall[2]=1 for exactly 2 cycles.
REQ-039 Pointer rotation: port 2 is granted bank 1, then ports 0 and 2 both request bank 1. Required: port 0 is granted first.
REQ-040 Read-after-write: port 1 writes 16'hBEEF to bank 2, addr 255, then port 0 reads that location the next cycle. Required: rdata=16'hBEEF.
REQ-041 Reset mid-read: assert rst in the cycle after a read grant. Required: rvalid=0 and rdata=0. Data written before reset SHALL still read back correctly after reset.
